// File: rtl/memory_access_unit.sv
// Load/store sequencer in front of a synchronous data memory: one request in
// flight, range-checked address, registered outputs, valid/ready on both sides.
package CPU_package;
  localparam int DATA_WIDTH    = 8;
  localparam int ADDRESS_WIDTH = 4;
endpackage

module memory_access_unit #(
  parameter int DATA_WIDTH        = CPU_package::DATA_WIDTH,
  parameter int ADDRESS_WIDTH     = CPU_package::ADDRESS_WIDTH,
  parameter int CPU_ADDRESS_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [CPU_ADDRESS_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]        req_wdata,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [DATA_WIDTH-1:0]        resp_data,
  output logic                         resp_error,
  output logic [7:0]                   error_count,
  output logic [ADDRESS_WIDTH-1:0]     write_address,
  output logic                         Write_Enable,
  output logic [DATA_WIDTH-1:0]        DATA_WRITE,
  output logic [ADDRESS_WIDTH-1:0]     read_address,
  output logic                         Read_Enable,
  input  logic [DATA_WIDTH-1:0]        DATA_READ
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_e;

  state_e                     state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]      resp_data_q, resp_data_d;
  logic                       resp_error_q, resp_error_d;
  logic [7:0]                 err_cnt_q, err_cnt_d;
  logic                       out_of_range;

  // Any CPU address bit above the memory's address range marks an error.
  assign out_of_range = |req_address[CPU_ADDRESS_WIDTH-1:ADDRESS_WIDTH];

  // NOTE: state and latches use non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // NOTE: every signal written here gets a hold/default value first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;
    err_cnt_d    = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_address[ADDRESS_WIDTH-1:0];
          wdata_d = req_wdata;
          if (out_of_range) begin
            resp_error_d = 1'b1;
            resp_data_d  = '0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            state_d = RESP;
          end else begin
            resp_error_d = 1'b0;
            state_d      = req_write ? WRITE : READ;
          end
        end
      end
      WRITE: begin
        resp_data_d = '0;
        state_d     = RESP;
      end
      READ:    state_d = CAPTURE;
      CAPTURE: begin
        // The memory updated DATA_READ on the edge that closed READ.
        resp_data_d = DATA_READ;
        state_d     = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = (state_q == RESP);
  assign Write_Enable  = (state_q == WRITE);
  assign Read_Enable   = (state_q == READ);
  assign write_address = addr_q;
  assign read_address  = addr_q;
  assign DATA_WRITE    = wdata_q;
  assign resp_data     = resp_data_q;
  assign resp_error    = resp_error_q;
  assign error_count   = err_cnt_q;

endmodule
